// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage of a five-stage RISC-V pipeline.
// Holds the EX/MEM register, drives a ready-handshake data-memory port,
// aligns/extends load data, encodes store lanes and stalls the pipeline
// while the memory inserts wait states. An optional wait limit turns a
// stuck access into a bus-error bubble instead of a permanent stall.
module mem_access_unit #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ValidE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  RdE,
    input  logic [31:0] PCplus4E,
    input  logic        RegWriteE,
    input  logic        MemReadE,
    input  logic        MemWriteE,
    input  logic [2:0]  Funct3E,
    input  logic [1:0]  ResultSrcE,
    output logic [31:0] ALUResultM,
    output logic [31:0] ReadDataM,
    output logic [31:0] PCplus4M,
    output logic [4:0]  RdM,
    output logic        RegWriteM,
    output logic [1:0]  ResultSrcM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    // Counter wide enough to hold WAIT_LIMIT; at least one bit.
    localparam int            CW           = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C      = CW'(WAIT_LIMIT);
    localparam logic          TIMEOUT_EN_C = (WAIT_LIMIT != 0);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Legal size/sign encoding with natural alignment; load+store together is never legal.
    function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] a,
                                          input logic is_load, input logic is_store);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~a[0];
            F3_W:    ok = (a == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok & ~(is_load & is_store);
    endfunction

    // Pick the addressed lane out of the read word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            2'b11:   b = w[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h000000, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0000, h};
            F3_W:    r = w;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Byte enables for a store of the given size at the given offset.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << a;
            F3_H:    be = 4'b0011 << a;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the access could land in.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {4{wd[7:0]}};
            F3_H:    r = {2{wd[15:0]}};
            F3_W:    r = wd;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          valid_q,     valid_d;
    logic [31:0]   alu_q,       alu_d;
    logic [31:0]   wd_q,        wd_d;
    logic [4:0]    rd_q,        rd_d;
    logic [31:0]   pc4_q,       pc4_d;
    logic          regwrite_q,  regwrite_d;
    logic          memread_q,   memread_d;
    logic          memwrite_q,  memwrite_d;
    logic [2:0]    funct3_q,    funct3_d;
    logic [1:0]    resultsrc_q, resultsrc_d;
    state_t        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;

    logic mem_access_s;
    logic legal_s;
    logic illegal_s;
    logic mem_op_s;
    logic timeout_s;
    logic req_s;
    logic ack_s;
    logic stall_s;
    logic wb_pass_s;

    // Classify the instruction held in M and derive handshake/stall status.
    // The timeout term does not look at dmem_ready, so there is no path
    // from dmem_ready back to dmem_req.
    always_comb begin
        mem_access_s = valid_q & (memread_q | memwrite_q);
        legal_s      = access_legal(funct3_q, alu_q[1:0], memread_q, memwrite_q);
        illegal_s    = mem_access_s & ~legal_s;
        mem_op_s     = mem_access_s & legal_s;
        timeout_s    = TIMEOUT_EN_C & (state_q == ST_WAIT) & (cnt_q == LIMIT_C);
        req_s        = mem_op_s & ~timeout_s;
        ack_s        = req_s & dmem_ready;
        stall_s      = req_s & ~dmem_ready;
        wb_pass_s    = valid_q & ~illegal_s & ~stall_s & ~timeout_s;
    end

    // Wait-state FSM; the counter counts stalled cycles of the current
    // access (the first stalled cycle included) and clears on completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (stall_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CW'(0);
                end
            end
            ST_WAIT: begin
                if (stall_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CW'(0);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CW'(0);
            end
        endcase
    end

    // EX/MEM register next value: hold on stall, bubble when E is empty.
    always_comb begin
        valid_d     = valid_q;
        alu_d       = alu_q;
        wd_d        = wd_q;
        rd_d        = rd_q;
        pc4_d       = pc4_q;
        regwrite_d  = regwrite_q;
        memread_d   = memread_q;
        memwrite_d  = memwrite_q;
        funct3_d    = funct3_q;
        resultsrc_d = resultsrc_q;
        if (stall_s) begin
            valid_d = valid_q;
        end else if (ValidE) begin
            valid_d     = 1'b1;
            alu_d       = ALUResultE;
            wd_d        = WriteDataE;
            rd_d        = RdE;
            pc4_d       = PCplus4E;
            regwrite_d  = RegWriteE;
            memread_d   = MemReadE;
            memwrite_d  = MemWriteE;
            funct3_d    = Funct3E;
            resultsrc_d = ResultSrcE;
        end else begin
            valid_d     = 1'b0;
            alu_d       = 32'h0000_0000;
            wd_d        = 32'h0000_0000;
            rd_d        = 5'd0;
            pc4_d       = 32'h0000_0000;
            regwrite_d  = 1'b0;
            memread_d   = 1'b0;
            memwrite_d  = 1'b0;
            funct3_d    = 3'b000;
            resultsrc_d = 2'b00;
        end
    end

    // All stage state; an async reset clears valid_q so dmem_req drops at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            alu_q       <= 32'h0000_0000;
            wd_q        <= 32'h0000_0000;
            rd_q        <= 5'd0;
            pc4_q       <= 32'h0000_0000;
            regwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            funct3_q    <= 3'b000;
            resultsrc_q <= 2'b00;
            state_q     <= ST_IDLE;
            cnt_q       <= CW'(0);
        end else begin
            valid_q     <= valid_d;
            alu_q       <= alu_d;
            wd_q        <= wd_d;
            rd_q        <= rd_d;
            pc4_q       <= pc4_d;
            regwrite_q  <= regwrite_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            funct3_q    <= funct3_d;
            resultsrc_q <= resultsrc_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    // Memory port: everything is gated by the request so an idle port is all zero.
    always_comb begin
        dmem_req = req_s;
        if (req_s) begin
            dmem_we    = memwrite_q;
            dmem_addr  = {alu_q[31:2], 2'b00};
            dmem_be    = memwrite_q ? store_be(funct3_q, alu_q[1:0]) : 4'b1111;
            dmem_wdata = memwrite_q ? store_wdata(funct3_q, wd_q) : 32'h0000_0000;
        end else begin
            dmem_we    = 1'b0;
            dmem_addr  = 32'h0000_0000;
            dmem_be    = 4'b0000;
            dmem_wdata = 32'h0000_0000;
        end
    end

    // Write-back view: stalled, illegal and timed-out instructions appear as bubbles.
    always_comb begin
        ALUResultM = alu_q;
        PCplus4M   = pc4_q;
        ResultSrcM = resultsrc_q;
        StallM     = stall_s;
        MisalignM  = illegal_s;
        BusErrM    = timeout_s;
        RegWriteM  = wb_pass_s & regwrite_q;
        RdM        = wb_pass_s ? rd_q : 5'd0;
        if (ack_s && memread_q) begin
            ReadDataM = load_extend(funct3_q, alu_q[1:0], dmem_rdata);
        end else begin
            ReadDataM = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a queue scoreboard: the stimulus
// pushes the expected retirement record, a monitor pops it when the DUT
// shows a retirement (write-back, misalign, bus error or memory handshake).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidE;
    logic [31:0] ALUResultE, WriteDataE, PCplus4E;
    logic [4:0]  RdE;
    logic        RegWriteE, MemReadE, MemWriteE;
    logic [2:0]  Funct3E;
    logic [1:0]  ResultSrcE;
    logic [31:0] ALUResultM, ReadDataM, PCplus4M;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        StallM, MisalignM, BusErrM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .ValidE(ValidE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE),
        .PCplus4E(PCplus4E), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
        .MemWriteE(MemWriteE), .Funct3E(Funct3E), .ResultSrcE(ResultSrcE),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCplus4M(PCplus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [1:0]  rs;
    } ins_t;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    exp_t act_m, exp_m;
    logic any_out;

    function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
        ins_t i;
        i = '0;
        i.valid = 1'b1; i.alu = alu; i.wd = wd; i.rd = rd;
        i.rw = rw; i.mr = mr; i.mw = mw; i.f3 = f3; i.rs = 2'b01;
        return i;
    endfunction

    function automatic exp_t e_ld(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] addr);
        exp_t e;
        e = '0;
        e.rw = 1'b1; e.rd = rd; e.rdata = data; e.req = 1'b1; e.be = 4'b1111; e.addr = addr;
        return e;
    endfunction

    function automatic exp_t e_st(input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] addr);
        exp_t e;
        e = '0;
        e.req = 1'b1; e.we = 1'b1; e.be = be; e.wdata = wdata; e.addr = addr;
        return e;
    endfunction

    function automatic exp_t e_flag(input logic mis, input logic berr);
        exp_t e;
        e = '0;
        e.mis = mis; e.berr = berr;
        return e;
    endfunction

    function automatic exp_t e_alu(input logic [4:0] rd);
        exp_t e;
        e = '0;
        e.rw = 1'b1; e.rd = rd;
        return e;
    endfunction

    task automatic drive_e(input ins_t i);
        ValidE = i.valid; ALUResultE = i.alu; WriteDataE = i.wd; RdE = i.rd;
        PCplus4E = i.alu + 32'd4; RegWriteE = i.rw; MemReadE = i.mr;
        MemWriteE = i.mw; Funct3E = i.f3; ResultSrcE = i.rs;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one instruction, let the memory answer after `waits` cycles,
    // count the stall cycles, and optionally feed `nx` in behind it.
    task automatic run(input string name, input ins_t i, input int waits, input logic [31:0] rdata,
                       input exp_t e, input int exp_stall,
                       input ins_t nx, input logic nx_chk, input exp_t enx);
        int stalls;
        sb_q.push_back(e);
        if (nx_chk) sb_q.push_back(enx);
        drive_e(i);
        @(posedge clk); #2;
        drive_e(nx);
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            dmem_ready = (k >= waits);
            dmem_rdata = rdata;
            @(negedge clk);
            if (StallM) stalls++;
            else break;
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0000_0000;
        drive_e('0);
        check({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
    endtask

    // Monitor: stall cycles must look like bubbles; retirements pop the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (StallM) begin
                check("stall_bubble", {26'd0, RegWriteM, RdM}, 32'd0);
            end
            if (RegWriteM || MisalignM || BusErrM || (dmem_req && dmem_ready)) begin
                act_m = {RegWriteM, RdM, ReadDataM, MisalignM, BusErrM,
                         dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr};
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_retire: got %h expected nothing", act_m);
                end else begin
                    exp_m = sb_q.pop_front();
                    if (act_m !== exp_m) begin
                        miscompares++;
                        $display("FAIL retire: got %h expected %h", act_m, exp_m);
                    end
                end
            end
        end
    end

    initial begin
        reset      = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0000_0000;
        drive_e('0);
        #3;
        any_out = |{ALUResultM, ReadDataM, PCplus4M, RdM, RegWriteM, ResultSrcM, StallM,
                    MisalignM, BusErrM, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata};
        check("reset_outputs", {31'd0, any_out}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Zero-wait LW
        run("lw_fast", mk(32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010), 0, 32'hDEADBEEF,
            e_ld(5'd5, 32'hDEADBEEF, 32'h100), 0, '0, 1'b0, '0);
        // LB / LBU on lane 3 with two wait states
        run("lb_wait", mk(32'h103, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000), 2, 32'h80FF_1234,
            e_ld(5'd6, 32'hFFFFFF80, 32'h100), 2, '0, 1'b0, '0);
        run("lbu_wait", mk(32'h103, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b100), 2, 32'h80FF_1234,
            e_ld(5'd6, 32'h00000080, 32'h100), 2, '0, 1'b0, '0);
        // LH / LHU upper half
        run("lh", mk(32'h102, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b001), 0, 32'h8001_0000,
            e_ld(5'd10, 32'hFFFF8001, 32'h100), 0, '0, 1'b0, '0);
        run("lhu", mk(32'h102, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b101), 0, 32'h8001_0000,
            e_ld(5'd10, 32'h00008001, 32'h100), 0, '0, 1'b0, '0);
        // Stores
        run("sh", mk(32'h202, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001), 0, 32'h0,
            e_st(4'b1100, 32'hABCDABCD, 32'h200), 0, '0, 1'b0, '0);
        run("sb", mk(32'h101, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000), 0, 32'h0,
            e_st(4'b0010, 32'h78787878, 32'h100), 0, '0, 1'b0, '0);
        // Illegal accesses
        run("lw_misalign", mk(32'h101, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010), 0, 32'h0,
            e_flag(1'b1, 1'b0), 0, '0, 1'b0, '0);
        run("ld_f3_011", mk(32'h101, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b011), 0, 32'h0,
            e_flag(1'b1, 1'b0), 0, '0, 1'b0, '0);
        run("rd_and_wr", mk(32'h100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 3'b010), 0, 32'h0,
            e_flag(1'b1, 1'b0), 0, '0, 1'b0, '0);
        run("sbu_illegal", mk(32'h100, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 3'b100), 0, 32'h0,
            e_flag(1'b1, 1'b0), 0, '0, 1'b0, '0);
        // Timeout with the next instruction waiting in E
        run("timeout", mk(32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010), 100, 32'h0,
            e_flag(1'b0, 1'b1), 4, mk(32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000), 1'b1,
            e_alu(5'd7));

        // Reset in the middle of a wait
        drive_e(mk(32'h400, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 3'b010));
        @(posedge clk); #2;
        drive_e('0);
        dmem_ready = 1'b0;
        @(negedge clk);
        check("pre_reset_stall", {31'd0, StallM}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, StallM}, 32'd0);
        any_out = |{ALUResultM, ReadDataM, PCplus4M, RdM, RegWriteM, ResultSrcM, StallM,
                    MisalignM, BusErrM, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata};
        check("rst_outputs", {31'd0, any_out}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        run("lw_after_rst", mk(32'h104, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010), 1, 32'h0BADF00D,
            e_ld(5'd8, 32'h0BADF00D, 32'h104), 1, '0, 1'b0, '0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access (M) stage of the five-stage RISC-V pipeline, directly upstream of the write-back unit.
- Holds the EX/MEM pipeline register and drives a ready-handshake data-memory port.
- Aligns and sign- or zero-extends load data, and builds byte enables and lane-replicated write data for stores.
- Stalls the pipeline during memory wait states and presents ALUResultM, ReadDataM, PCplus4M and RdM to write-back.

Parameters:
- WAIT_LIMIT, 0: maximum WAIT cycles before a bus timeout; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock; all registers rising-edge.
- reset  in  1  asynchronous, active-low reset.
- ValidE  in  1  execute stage holds a real instruction.
- ALUResultE  in  32  effective address or ALU result.
- WriteDataE  in  32  store data (rs2).
- RdE  in  5  destination register.
- PCplus4E  in  32  PC+4 of the instruction.
- RegWriteE  in  1  instruction writes rd.
- MemReadE  in  1  load.
- MemWriteE  in  1  store.
- Funct3E  in  3  access size and sign.
- ResultSrcE  in  2  result select passed to write-back.
- ALUResultM  out  32  registered ALU result.
- ReadDataM  out  32  extended load data.
- PCplus4M  out  32  registered PC+4.
- RdM  out  5  destination; 0 on a bubble.
- RegWriteM  out  1  write enable to write-back; 0 on a bubble.
- ResultSrcM  out  2  registered result select.
- StallM  out  1  freeze IF/ID/EX and the M register.
- MisalignM  out  1  one-cycle pulse: misaligned or illegal access.
- BusErrM  out  1  one-cycle pulse: bus timeout.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  access complete this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ready is high.

Behaviour:
- Reset (async, reset=0):
  - All M registers clear; state goes to IDLE; wait counter clears.
  - Every output is 0, including dmem_req and StallM.
  - A reset during WAIT abandons the access immediately; dmem_req drops asynchronously.
- M register capture:
  - When StallM=0, the register loads the E inputs on each clk edge.
  - ValidE=0 loads a bubble: all control bits 0.
  - When StallM=1, the register holds.
- Memory op: the M register is valid, (MemRead|MemWrite)=1, and the access is legal. MemRead and MemWrite both set is illegal.
- Legality rules:
  - Loads: funct3 000/100 (byte), 001/101 (half, addr[0]=0), 010 (word, addr[1:0]=0).
  - Stores: funct3 000, 001 or 010, with the same alignment rules.
  - Anything else is illegal: no request, MisalignM=1 for that cycle, RegWriteM=0, RdM=0, no stall.
- dmem_req is combinational from the M register: asserted in both IDLE and WAIT while a legal memory op is present. Address, be, we and wdata stay stable until the dmem_ready cycle.
- FSM, two states:
  - IDLE → WAIT when a memory op is present and dmem_ready=0.
  - WAIT → IDLE on dmem_ready=1.
  - WAIT → IDLE on a timeout: WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT.
  - The counter increments on each WAIT cycle and clears on leaving WAIT.
- Zero-wait access: dmem_ready=1 in the same cycle as the first request completes with no stall and no WAIT entry.
- StallM = memory op present & dmem_ready=0 & no timeout this cycle.
- Write-back presentation while StallM=1: bubble (RegWriteM=0, RdM=0). Write-back never captures a stale load.
- Load data: ReadDataM is combinational from dmem_rdata in the ready cycle.
  - Byte lane selected by addr[1:0]; half lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - ReadDataM is 0 when no load completes.
- Store encoding:
  - SB: be=0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{wd[15:0]}}.
  - SW: be=1111, wdata=wd.
  - Loads drive be=1111, we=0.
- Timeout cycle: dmem_req drops, BusErrM=1 for one cycle, the instruction retires as a bubble, and StallM=0 so the M register advances.
- dmem_ready is ignored whenever dmem_req=0.

Test Plan:
- LW, addr 0x100, dmem_ready=1 on the first cycle, rdata 0xDEADBEEF → no StallM; ReadDataM=0xDEADBEEF; RegWriteM=1; RdM=RdE.
- LB, addr 0x103, rdata 0x80FF_1234, 2 wait cycles → StallM high for 2 cycles with RegWriteM=0; ReadDataM=0xFFFFFF80 in the ready cycle; LBU variant gives 0x00000080.
- SH, addr 0x202, WriteDataE=0x0000ABCD, ready immediately → dmem_we=1, be=1100, wdata=0xABCDABCD, addr=0x200; RegWriteM=0.
- LW at addr 0x101 → dmem_req=0, MisalignM pulses 1 cycle, no stall; repeat with funct3=011 → same response.
- WAIT_LIMIT=4, load with dmem_ready held 0 → StallM high for 4 cycles, then BusErrM pulses, dmem_req drops, the next instruction enters M.
- Assert reset low during WAIT → dmem_req and StallM go to 0 asynchronously and all outputs read 0; after release, a fresh LW completes normally.
